// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer port controller: default geometry,
// clear-engine state encoding and the pixel type.
package fb_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 24;
    localparam int FB_DEPTH  = 2001;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    typedef logic [FB_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/fb_port_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; req[0]/gnt[0] is the host, req[1]/gnt[1] the draw engine.
// Grants are combinational from the registered pointer, which only moves on a grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // r_ptr = 0 means requester 0 has priority on the next contention
    logic r_ptr;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (o_gnt[0]) begin
            r_ptr <= 1'b1;
        end else if (o_gnt[1]) begin
            r_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/fb_port_ctrl.sv
// Frame-buffer port controller: arbitrated port A with a fill engine that can
// own the port, plus read-valid tracking for the scanout reader on port B.
module fb_port_ctrl
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = FB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [DATA_W-1:0] mem_data_a,
    output logic              mem_we_a,
    input  logic [DATA_W-1:0] mem_q_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic [DATA_W-1:0] mem_data_b,
    output logic              mem_we_b,
    input  logic [DATA_W-1:0] mem_q_b
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_clrCnt;
    logic [DATA_W-1:0] r_clrColor;
    logic              r_clrDone;
    logic              r_hRvalid, r_hOor;
    logic              r_dRvalid, r_dOor;
    logic              r_scanValid;
    logic [1:0]        w_req, w_gnt;
    logic              w_hInRange, w_dInRange;

    // The fill engine owns port A outright, so requests are masked while clearing
    assign w_req = {d_req, h_req} & {2{r_state == IDLE}};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign h_gnt      = w_gnt[0];
    assign d_gnt      = w_gnt[1];
    assign w_hInRange = (h_addr < DEPTH_A);
    assign w_dInRange = (d_addr < DEPTH_A);

    always_comb begin
        mem_addr_a = '0;
        mem_data_a = '0;
        mem_we_a   = 1'b0;
        if (r_state == CLEAR) begin
            mem_addr_a = r_clrCnt;
            mem_data_a = r_clrColor;
            mem_we_a   = 1'b1;
        end else if (w_gnt[0]) begin
            mem_addr_a = h_addr;
            mem_data_a = h_wdata;
            mem_we_a   = h_we & w_hInRange;
        end else if (w_gnt[1]) begin
            mem_addr_a = d_addr;
            mem_data_a = d_wdata;
            mem_we_a   = d_we & w_dInRange;
        end
    end

    // Clear engine: one write per cycle from 0 to DEPTH-1, done pulse afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_clrCnt   <= '0;
            r_clrColor <= '0;
            r_clrDone  <= 1'b0;
        end else begin
            r_clrDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (clr_start) begin
                        r_clrColor <= clr_color;
                        r_clrCnt   <= '0;
                        r_state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (r_clrCnt == LAST_ADDR) begin
                        r_state   <= IDLE;
                        r_clrDone <= 1'b1;
                    end else begin
                        r_clrCnt <= r_clrCnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Out-of-range reads still return a valid beat, but with zero data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hRvalid   <= 1'b0;
            r_hOor      <= 1'b0;
            r_dRvalid   <= 1'b0;
            r_dOor      <= 1'b0;
            r_scanValid <= 1'b0;
        end else begin
            r_hRvalid   <= w_gnt[0] & ~h_we;
            r_hOor      <= ~w_hInRange;
            r_dRvalid   <= w_gnt[1] & ~d_we;
            r_dOor      <= ~w_dInRange;
            r_scanValid <= scan_req;
        end
    end

    assign h_rvalid   = r_hRvalid;
    assign h_rdata    = (r_hRvalid && !r_hOor) ? mem_q_a : '0;
    assign d_rvalid   = r_dRvalid;
    assign d_rdata    = (r_dRvalid && !r_dOor) ? mem_q_a : '0;
    assign clr_busy   = (r_state == CLEAR);
    assign clr_done   = r_clrDone;
    assign scan_valid = r_scanValid;
    assign scan_data  = r_scanValid ? mem_q_b : '0;
    assign mem_addr_b = scan_addr;
    assign mem_data_b = '0;
    assign mem_we_b   = 1'b0;

endmodule

// File: tb/tb_fb_port_ctrl.sv
// Directed bench for fb_port_ctrl with a small dual-port RAM model and DEPTH=8.
module tb_fb_port_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 24;
    localparam int DEP = 8;

    logic          clk, rst;
    logic          h_req, h_we, h_gnt, h_rvalid;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata, h_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          clr_start, clr_busy, clr_done;
    logic [DW-1:0] clr_color;
    logic          scan_req, scan_valid;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_data;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [DW-1:0] mem_data_a, mem_data_b, mem_q_a, mem_q_b;
    logic          mem_we_a, mem_we_b;

    int checks   = 0;
    int failures = 0;

    fb_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .mem_addr_a(mem_addr_a), .mem_data_a(mem_data_a), .mem_we_a(mem_we_a), .mem_q_a(mem_q_a),
        .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b), .mem_we_b(mem_we_b), .mem_q_b(mem_q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write-first, 1-cycle read; unused high addresses read a marker value
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_we_a) ram[mem_addr_a[7:0]] <= mem_data_a;
        if (mem_we_b) ram[mem_addr_b[7:0]] <= mem_data_b;
        mem_q_a <= mem_we_a ? mem_data_a : ((mem_addr_a >= 16'(DEP)) ? 24'h999999 : ram[mem_addr_a[7:0]]);
        mem_q_b <= mem_we_b ? mem_data_b : ((mem_addr_b >= 16'(DEP)) ? 24'h999999 : ram[mem_addr_b[7:0]]);
    end

    task automatic set_idle();
        h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        clr_start = 0; clr_color = '0; scan_req = 0; scan_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1; set_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (clr_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%0h exp=0", clr_busy); end
        checks++; if (clr_done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%0h exp=0", clr_done); end
        checks++; if ({h_rvalid, d_rvalid, scan_valid} !== 3'b000) begin failures++; $display("[TB] FAIL rst_valids got=%b exp=000", {h_rvalid, d_rvalid, scan_valid}); end
        checks++; if (h_rdata !== 24'h0) begin failures++; $display("[TB] FAIL rst_hrdata got=%h exp=000000", h_rdata); end
        checks++; if ({mem_we_a, mem_addr_a} !== 17'h0) begin failures++; $display("[TB] FAIL rst_porta got=%h exp=0", {mem_we_a, mem_addr_a}); end
        rst = 0;
    endtask

    task automatic test_host_rw();
        @(posedge clk); #1;
        h_req = 1; h_we = 1; h_addr = 16'd5; h_wdata = 24'h00FF00;
        #1;
        checks++; if ({h_gnt, d_gnt} !== 2'b10) begin failures++; $display("[TB] FAIL hrw_wr_gnt got=%b exp=10", {h_gnt, d_gnt}); end
        checks++; if ({mem_we_a, mem_addr_a, mem_data_a} !== {1'b1, 16'd5, 24'h00FF00}) begin failures++; $display("[TB] FAIL hrw_wr_porta got=%h exp=%h", {mem_we_a, mem_addr_a, mem_data_a}, {1'b1, 16'd5, 24'h00FF00}); end
        @(posedge clk); #1;
        h_we = 0;
        #1;
        checks++; if ({h_gnt, d_gnt} !== 2'b10) begin failures++; $display("[TB] FAIL hrw_rd_gnt got=%b exp=10", {h_gnt, d_gnt}); end
        checks++; if (h_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL hrw_wr_no_rvalid got=%0h exp=0", h_rvalid); end
        @(posedge clk); #1;
        h_req = 0;
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== 24'h00FF00) begin failures++; $display("[TB] FAIL hrw_rdata got=%0h/%h exp=1/00ff00", h_rvalid, h_rdata); end
        checks++; if ({d_rvalid, d_gnt} !== 2'b00) begin failures++; $display("[TB] FAIL hrw_draw_idle got=%b exp=00", {d_rvalid, d_gnt}); end
        @(posedge clk); #1;
        checks++; if (h_rvalid !== 1'b0 || h_rdata !== 24'h0) begin failures++; $display("[TB] FAIL hrw_rvalid_drop got=%0h/%h exp=0/000000", h_rvalid, h_rdata); end
    endtask

    task automatic test_draw_read();
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 16'd5;
        #1;
        checks++; if ({h_gnt, d_gnt} !== 2'b01) begin failures++; $display("[TB] FAIL draw_gnt got=%b exp=01", {h_gnt, d_gnt}); end
        @(posedge clk); #1;
        d_req = 0;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 24'h00FF00) begin failures++; $display("[TB] FAIL draw_rdata got=%0h/%h exp=1/00ff00", d_rvalid, d_rdata); end
        checks++; if (h_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL draw_h_quiet got=%0h exp=0", h_rvalid); end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] expAddr [0:3];
        expAddr[0] = 16'd0; expAddr[1] = 16'd6; expAddr[2] = 16'd1; expAddr[3] = 16'd7;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            h_req = 1; h_we = 1; h_addr = 16'((i + 1) / 2); h_wdata = 24'hA00000 + 24'(i);
            d_req = 1; d_we = 1; d_addr = 16'(6 + i / 2);   d_wdata = 24'hB00000 + 24'(i);
            #1;
            checks++; if ({h_gnt, d_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("[TB] FAIL b2b_gnt[%0d] got=%b exp=%b", i, {h_gnt, d_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            checks++; if ({mem_we_a, mem_addr_a} !== {1'b1, expAddr[i]}) begin failures++; $display("[TB] FAIL b2b_addr[%0d] got=%h exp=%h", i, {mem_we_a, mem_addr_a}, {1'b1, expAddr[i]}); end
            @(posedge clk); #1;
        end
        set_idle();
    endtask

    task automatic test_clear();
        @(posedge clk); #1;
        clr_start = 1; clr_color = 24'h123456;
        h_req = 1; h_we = 0; h_addr = 16'd5;
        #1;
        checks++; if (h_gnt !== 1'b1 || clr_busy !== 1'b0) begin failures++; $display("[TB] FAIL clr_start_cycle got=%0h/%0h exp=1/0", h_gnt, clr_busy); end
        @(posedge clk); #1;
        clr_start = 0;
        for (int i = 0; i < DEP; i++) begin
            if (i == 4) begin scan_req = 1; scan_addr = 16'd2; clr_start = 1; clr_color = 24'h654321; end
            #1;
            checks++; if (clr_busy !== 1'b1 || clr_done !== 1'b0) begin failures++; $display("[TB] FAIL clr_busy[%0d] got=%0h/%0h exp=1/0", i, clr_busy, clr_done); end
            checks++; if ({mem_we_a, mem_addr_a, mem_data_a} !== {1'b1, 16'(i), 24'h123456}) begin failures++; $display("[TB] FAIL clr_write[%0d] got=%h exp=%h", i, {mem_we_a, mem_addr_a, mem_data_a}, {1'b1, 16'(i), 24'h123456}); end
            checks++; if ({h_gnt, d_gnt} !== 2'b00) begin failures++; $display("[TB] FAIL clr_no_gnt[%0d] got=%b exp=00", i, {h_gnt, d_gnt}); end
            if (i == 0) begin
                checks++; if (h_rvalid !== 1'b1 || h_rdata !== 24'h00FF00) begin failures++; $display("[TB] FAIL clr_pre_read got=%0h/%h exp=1/00ff00", h_rvalid, h_rdata); end
            end
            if (i == 1) begin
                checks++; if (h_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL clr_no_rvalid got=%0h exp=0", h_rvalid); end
            end
            if (i == 4) begin
                checks++; if ({mem_we_b, mem_addr_b, mem_data_b} !== {1'b0, 16'd2, 24'h0}) begin failures++; $display("[TB] FAIL scan_portb got=%h exp=%h", {mem_we_b, mem_addr_b, mem_data_b}, {1'b0, 16'd2, 24'h0}); end
            end
            if (i == 5) begin
                scan_req = 0; clr_start = 0;
                checks++; if (scan_valid !== 1'b1 || scan_data !== 24'h123456) begin failures++; $display("[TB] FAIL scan_data got=%0h/%h exp=1/123456", scan_valid, scan_data); end
            end
            if (i == 6) begin
                checks++; if (scan_valid !== 1'b0 || scan_data !== 24'h0) begin failures++; $display("[TB] FAIL scan_drop got=%0h/%h exp=0/000000", scan_valid, scan_data); end
            end
            @(posedge clk); #1;
        end
        #1;
        checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b1) begin failures++; $display("[TB] FAIL clr_end got=%0h/%0h exp=0/1", clr_busy, clr_done); end
        checks++; if (h_gnt !== 1'b1 || mem_addr_a !== 16'd5 || mem_we_a !== 1'b0) begin failures++; $display("[TB] FAIL clr_resume got=%0h/%h/%0h exp=1/0005/0", h_gnt, mem_addr_a, mem_we_a); end
        @(posedge clk); #1;
        h_req = 0;
        checks++; if (clr_done !== 1'b0) begin failures++; $display("[TB] FAIL clr_done_pulse got=%0h exp=0", clr_done); end
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== 24'h123456) begin failures++; $display("[TB] FAIL clr_readback got=%0h/%h exp=1/123456", h_rvalid, h_rdata); end
    endtask

    task automatic test_clear_reset();
        logic [AW-1:0] rdAddr [0:3];
        logic [DW-1:0] rdExp  [0:3];
        rdAddr[0] = 16'd2; rdExp[0] = 24'hABCDEF;
        rdAddr[1] = 16'd3; rdExp[1] = 24'h123456;
        rdAddr[2] = 16'd4; rdExp[2] = 24'h123456;
        rdAddr[3] = 16'd7; rdExp[3] = 24'h123456;
        @(posedge clk); #1;
        clr_start = 1; clr_color = 24'hABCDEF;
        @(posedge clk); #1;
        clr_start = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (mem_addr_a !== 16'(i)) begin failures++; $display("[TB] FAIL crst_addr[%0d] got=%h exp=%h", i, mem_addr_a, 16'(i)); end
            if (i < 3) begin @(posedge clk); #1; end
        end
        rst = 1;
        #1;
        checks++; if ({clr_busy, clr_done, mem_we_a} !== 3'b000) begin failures++; $display("[TB] FAIL crst_abort got=%b exp=000", {clr_busy, clr_done, mem_we_a}); end
        @(posedge clk); #1;
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            h_req = 1; h_we = 0; h_addr = rdAddr[k];
            @(posedge clk); #1;
            h_req = 0;
            checks++; if (h_rvalid !== 1'b1 || h_rdata !== rdExp[k]) begin failures++; $display("[TB] FAIL crst_keep[%0d] got=%0h/%h exp=1/%h", k, h_rvalid, h_rdata, rdExp[k]); end
            checks++; if (clr_done !== 1'b0) begin failures++; $display("[TB] FAIL crst_no_done[%0d] got=%0h exp=0", k, clr_done); end
        end
    endtask

    task automatic test_out_of_range();
        @(posedge clk); #1;
        h_req = 1; h_we = 1; h_addr = 16'(DEP - 1); h_wdata = 24'h0F0F0F;
        #1;
        checks++; if (h_gnt !== 1'b1 || mem_we_a !== 1'b1) begin failures++; $display("[TB] FAIL oor_last_wr got=%0h/%0h exp=1/1", h_gnt, mem_we_a); end
        @(posedge clk); #1;
        h_addr = 16'(DEP); h_wdata = 24'h777777;
        #1;
        checks++; if (h_gnt !== 1'b1 || mem_we_a !== 1'b0) begin failures++; $display("[TB] FAIL oor_wr got=%0h/%0h exp=1/0", h_gnt, mem_we_a); end
        @(posedge clk); #1;
        h_we = 0;
        #1;
        checks++; if (h_gnt !== 1'b1) begin failures++; $display("[TB] FAIL oor_rd_gnt got=%0h exp=1", h_gnt); end
        @(posedge clk); #1;
        h_req = 0;
        checks++; if (h_rvalid !== 1'b1 || h_rdata !== 24'h0) begin failures++; $display("[TB] FAIL oor_rdata got=%0h/%h exp=1/000000", h_rvalid, h_rdata); end
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_draw_read();
        test_back_to_back();
        test_clear();
        test_clear_reset();
        test_out_of_range();
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
